// File: rtl/ahb_slave_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_slave_arbiter
//   Per-slave AHB arbiter. One slave port is shared between MASTER_NUM
//   masters. A grant goes to exactly one requester and is held for that
//   master's whole burst, until its last beat completes or it drops hreq.
//
//   Optional build macro: DYNAMIC_PRIORITY_ARBITER_EN
//     defined   : hprior port and PRIOR_BIT parameter exist. The winner is the
//                 requester with the highest hprior. Ties go to round-robin
//                 order starting at rr_ptr+1.
//     undefined : pure round-robin from rr_ptr+1.
//
// Ports
//   hclk        in   bus clock, rising edge
//   hreset_n    in   synchronous active-low reset
//   hreq        in   [MASTER_NUM-1:0] per-master request, level
//   hlast       in   [MASTER_NUM-1:0] per-master "current beat is last"
//   hwait       in   slave stall; a beat does not complete while high
//   hprior      in   [MASTER_NUM*PRIOR_BIT-1:0] priorities (macro only)
//   hgrant      out  [MASTER_NUM-1:0] one-hot grant, registered
//   hsel        out  slave select (== |hgrant), registered
//   hmaster_id  out  [ID_W-1:0] index of the granted master, registered
//   arb_state   out  FSM state for debug (0 = ARB_IDLE, 1 = ARB_OWN)
//
// Handshake: a beat completes on a rising edge where hwait is low. The
// owner's burst ends on a completing beat with hlast[owner]=1, or as soon as
// the owner drops hreq (hwait does not block that case). Requests are
// levels; a master keeps hreq high until it sees its grant.
// ---------------------------------------------------------------------------
module ahb_slave_arbiter #(
    parameter int MASTER_NUM = 4
`ifdef DYNAMIC_PRIORITY_ARBITER_EN
  , parameter int PRIOR_BIT  = 2
`endif
) (
    input  logic                            hclk,
    input  logic                            hreset_n,
    input  logic [MASTER_NUM-1:0]           hreq,
    input  logic [MASTER_NUM-1:0]           hlast,
    input  logic                            hwait,
`ifdef DYNAMIC_PRIORITY_ARBITER_EN
    input  logic [MASTER_NUM*PRIOR_BIT-1:0] hprior,
`endif
    output logic [MASTER_NUM-1:0]           hgrant,
    output logic                            hsel,
    output logic [$clog2(MASTER_NUM)-1:0]   hmaster_id,
    output logic                            arb_state
);

    localparam int ID_W = $clog2(MASTER_NUM);

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

    arb_state_e            state, state_nxt;
    logic [ID_W-1:0]       rr_ptr, rr_nxt;
    logic [ID_W-1:0]       owner_nxt;
    logic [MASTER_NUM-1:0] grant_nxt;
    logic                  sel_nxt;

    logic [MASTER_NUM-1:0] owner_mask;
    logic [MASTER_NUM-1:0] arb_req;
    logic [ID_W-1:0]       arb_ptr;
    logic [ID_W:0]         arb_sum;
    logic [ID_W-1:0]       arb_idx;
    logic                  win_valid;
    logic [ID_W-1:0]       win_id;
    logic                  release_evt;
`ifdef DYNAMIC_PRIORITY_ARBITER_EN
    logic [PRIOR_BIT-1:0]  cand_prior;
    logic [PRIOR_BIT-1:0]  best_prior;
`endif

    assign arb_state = state;

    // The owner's bit is masked during a release so another requester gets
    // the slot first; the search also starts right after the owner, which is
    // the pointer value being written on that same edge.
    always_comb begin
        owner_mask             = '0;
        owner_mask[hmaster_id] = 1'b1;
        if (state == ARB_OWN) begin
            arb_req = hreq & ~owner_mask;
            arb_ptr = hmaster_id;
        end else begin
            arb_req = hreq;
            arb_ptr = rr_ptr;
        end
        release_evt = (hlast[hmaster_id] & ~hwait) | ~hreq[hmaster_id];
    end

    // Search from arb_ptr+1 upwards with wrap. In round-robin mode the first
    // set request wins; in priority mode a later candidate only wins with a
    // strictly higher priority, so ties fall to round-robin order.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        arb_sum   = '0;
        arb_idx   = '0;
`ifdef DYNAMIC_PRIORITY_ARBITER_EN
        cand_prior = '0;
        best_prior = '0;
`endif
        for (int i = 1; i <= MASTER_NUM; i++) begin
            arb_sum = {1'b0, arb_ptr} + (ID_W+1)'(i);
            if (arb_sum >= (ID_W+1)'(MASTER_NUM))
                arb_sum = arb_sum - (ID_W+1)'(MASTER_NUM);
            arb_idx = arb_sum[ID_W-1:0];
`ifdef DYNAMIC_PRIORITY_ARBITER_EN
            cand_prior = hprior[arb_idx*PRIOR_BIT +: PRIOR_BIT];
            if (arb_req[arb_idx] && (!win_valid || cand_prior > best_prior)) begin
                win_valid  = 1'b1;
                win_id     = arb_idx;
                best_prior = cand_prior;
            end
`else
            if (arb_req[arb_idx] && !win_valid) begin
                win_valid = 1'b1;
                win_id    = arb_idx;
            end
`endif
        end
    end

    // State register (outputs are registered alongside it)
    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            state      <= ARB_IDLE;
            rr_ptr     <= ID_W'(MASTER_NUM - 1);
            hgrant     <= '0;
            hsel       <= 1'b0;
            hmaster_id <= '0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_nxt;
            hgrant     <= grant_nxt;
            hsel       <= sel_nxt;
            hmaster_id <= owner_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        owner_nxt = hmaster_id;
        case (state)
            ARB_IDLE: begin
                if (win_valid) begin
                    state_nxt = ARB_OWN;
                    owner_nxt = win_id;
                end
            end
            ARB_OWN: begin
                if (release_evt) begin
                    rr_nxt = hmaster_id;
                    if (win_valid)
                        owner_nxt = win_id;
                    else if (!hreq[hmaster_id])
                        state_nxt = ARB_IDLE;
                    // else: owner still requesting and alone, it re-wins
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Output logic: values loaded into the output registers. In idle the
    // master id keeps its last value.
    always_comb begin
        grant_nxt = '0;
        sel_nxt   = (state_nxt == ARB_OWN);
        if (sel_nxt)
            grant_nxt[owner_nxt] = 1'b1;
    end

endmodule
